sqr_acc: RTL and testbench

SQR_ACC -- requirements
Module: sqr_acc

---
 rtl/sqr_acc.sv | 102 ++++++++++
 tb/tb_sqr_acc.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sqr_acc.sv
// Sum-of-squares accumulator: squares CNT samples per block and presents the total with valid/ready.
// Optional macro SQR_ACC_SIGNED_EN treats x as two's-complement instead of unsigned.
module sqr_acc #(
    parameter  int I_LEN = 16,
    parameter  int CNT   = 8,
    localparam int O_LEN = 2 * I_LEN + $clog2(CNT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic [I_LEN-1:0]   x,
    input  logic               x_vld,
    output logic               x_rdy,
    output logic [O_LEN-1:0]   y,
    output logic               y_vld,
    input  logic               y_rdy
);

    localparam int CW = (CNT > 1) ? $clog2(CNT) : 1;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [O_LEN-1:0]       acc;
    logic [CW-1:0]          cnt;
    logic                   accept;
    logic                   last;
    logic [2*I_LEN-1:0]     x_ext;
    logic [2*I_LEN-1:0]     sq;
    logic [O_LEN-1:0]       sum;

    // Extending to full product width first lets one multiply serve both number formats.
`ifdef SQR_ACC_SIGNED_EN
    assign x_ext = {{I_LEN{x[I_LEN-1]}}, x};
`else
    assign x_ext = {{I_LEN{1'b0}}, x};
`endif

    assign sq   = x_ext * x_ext;
    assign sum  = acc + O_LEN'(sq);
    assign last = (cnt == CW'(CNT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACC;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        x_rdy      = 1'b0;
        y_vld      = 1'b0;
        accept     = 1'b0;
        case (state)
            ACC: begin
                x_rdy  = 1'b1;
                accept = x_vld && !clr;
                if (accept && last) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                y_vld = 1'b1;
                if (y_rdy) begin
                    next_state = ACC;
                end
            end
            default: next_state = ACC;
        endcase
        if (clr) begin
            next_state = ACC;
        end
    end

    // Accumulator and counter are zeroed as the block completes, so HOLD exits straight into a fresh block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
            y   <= '0;
        end else if (clr) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            if (last) begin
                y   <= sum;
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_sqr_acc.sv
// Randomized scoreboard bench for sqr_acc, plus a small directed check of a CNT=1, I_LEN=4 instance.
// Honours SQR_ACC_SIGNED_EN in its reference squaring.
module tb_sqr_acc;

    localparam int I_LEN  = 16;
    localparam int CNT    = 8;
    localparam int O_LEN  = 2 * I_LEN + $clog2(CNT);
    localparam int O_LEN1 = 8;

    logic              clk;
    logic              rst_n;
    logic              clr;
    logic [I_LEN-1:0]  x;
    logic              x_vld;
    logic              x_rdy;
    logic [O_LEN-1:0]  y;
    logic              y_vld;
    logic              y_rdy;

    logic              clr1;
    logic [3:0]        x1;
    logic              x1_vld;
    logic              x1_rdy;
    logic [O_LEN1-1:0] y1;
    logic              y1_vld;
    logic              y1_rdy;

    int                n_cmp;
    int                n_bad;
    longint unsigned   exp_q[$];
    logic [I_LEN-1:0]  blk[$];
    bit                hold;
    longint unsigned   model_y;
    bit                prev_vld;

    sqr_acc #(.I_LEN(I_LEN), .CNT(CNT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .x     (x),
        .x_vld (x_vld),
        .x_rdy (x_rdy),
        .y     (y),
        .y_vld (y_vld),
        .y_rdy (y_rdy)
    );

    sqr_acc #(.I_LEN(4), .CNT(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr1),
        .x     (x1),
        .x_vld (x1_vld),
        .x_rdy (x1_rdy),
        .y     (y1),
        .y_vld (y1_vld),
        .y_rdy (y1_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint unsigned sq_of(input logic [I_LEN-1:0] v);
        longint s;
`ifdef SQR_ACC_SIGNED_EN
        s = longint'($signed(v));
`else
        s = longint'(v);
`endif
        return longint'(s * s);
    endfunction

    task automatic checkOutput(input string name, input longint unsigned actual,
                               input longint unsigned expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one cycle of inputs and advances the block-level model to the state after the coming edge.
    task automatic applyStimulus(input bit c, input bit v, input logic [I_LEN-1:0] d, input bit r);
        longint unsigned total;
        @(negedge clk);
        clr   = c;
        x_vld = v;
        x     = d;
        y_rdy = r;
        if (c) begin
            blk.delete();
            hold = 1'b0;
        end else if (hold) begin
            if (r) hold = 1'b0;
        end else if (v) begin
            blk.push_back(d);
            if (blk.size() == CNT) begin
                total = 0;
                foreach (blk[i]) total += sq_of(blk[i]);
                exp_q.push_back(total);
                blk.delete();
                hold = 1'b1;
            end
        end
    endtask

    task automatic checkAfterEdge(input string name, input longint unsigned expected);
        @(posedge clk);
        #1;
        checkOutput(name, 64'(y), expected);
    endtask

    task automatic asyncReset();
        @(negedge clk);
        #2;
        rst_n   = 1'b0;
        blk.delete();
        hold    = 1'b0;
        model_y = 0;
        #1;
        checkOutput("rst_y", 64'(y), 0);
        checkOutput("rst_y_vld", 64'(y_vld), 0);
        checkOutput("rst_x_rdy", 64'(x_rdy), 1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: pops the expected sum whenever a new result appears and checks handshake outputs every cycle.
    initial begin
        prev_vld = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (y_vld && !prev_vld) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("[TB] FAIL unexpected_result: got y=%0d with no result expected", y);
                end else begin
                    model_y = exp_q.pop_front();
                end
            end
            checkOutput("y_vld", 64'(y_vld), 64'(hold));
            checkOutput("x_rdy", 64'(x_rdy), 64'(!hold));
            checkOutput("y", 64'(y), model_y);
            prev_vld = y_vld;
        end
    end

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        hold    = 1'b0;
        model_y = 0;
        rst_n   = 1'b0;
        clr     = 1'b0;
        x       = '0;
        x_vld   = 1'b0;
        y_rdy   = 1'b0;
        clr1    = 1'b0;
        x1      = '0;
        x1_vld  = 1'b0;
        y1_rdy  = 1'b0;
        #1;
        checkOutput("init_y", 64'(y), 0);
        checkOutput("init_x_rdy", 64'(x_rdy), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 1; i <= 8; i++) applyStimulus(1'b0, 1'b1, I_LEN'(i), 1'b1);
        checkAfterEdge("basic_sum", 204);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);

        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 16'hFFFF, 1'b1);
`ifdef SQR_ACC_SIGNED_EN
        checkAfterEdge("max_ffff", 8);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 16'h8000, 1'b1);
        checkAfterEdge("max_8000", 64'd8589934592);
`else
        checkAfterEdge("max_ffff", 64'd34358689800);
`endif
        applyStimulus(1'b0, 1'b0, '0, 1'b1);

        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 16'd3, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'd3, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 16'd9, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'd5, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 16'd5, 1'b1);
        checkAfterEdge("after_backpressure", 200);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);

        applyStimulus(1'b0, 1'b1, 16'd3, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b1, 16'd4, 1'b1);
        applyStimulus(1'b1, 1'b1, 16'd100, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 16'd2, 1'b1);
        checkAfterEdge("after_clear", 32);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);

        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 16'd7, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        asyncReset();
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 16'd1, 1'b1);
        checkAfterEdge("after_reset", 8);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 16'd6, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        asyncReset();

        for (int i = 0; i < 400; i++) begin
            logic [I_LEN-1:0] d;
            case ($urandom_range(0, 5))
                0:       d = 16'hFFFF;
                1:       d = 16'h8000;
                2:       d = 16'h0000;
                3:       d = I_LEN'($urandom_range(0, 15));
                default: d = I_LEN'($urandom);
            endcase
            applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7, d,
                          $urandom_range(0, 9) < 6);
        end

        for (int i = 0; i < 50 && (hold || exp_q.size() != 0); i++) applyStimulus(1'b0, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        @(posedge clk);
        #2;
        checkOutput("results_drained", 64'(exp_q.size()), 0);

        @(negedge clk);
        x1     = 4'd15;
        x1_vld = 1'b1;
        y1_rdy = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("cnt1_y", 64'(y1), 225);
        checkOutput("cnt1_y_vld", 64'(y1_vld), 1);
        checkOutput("cnt1_x_rdy", 64'(x1_rdy), 0);
        @(negedge clk);
        x1 = 4'd3;
        @(posedge clk);
        #1;
        checkOutput("cnt1_gap_vld", 64'(y1_vld), 0);
        checkOutput("cnt1_gap_y", 64'(y1), 225);
        @(posedge clk);
        #1;
        checkOutput("cnt1_second_y", 64'(y1), 9);
        checkOutput("cnt1_second_vld", 64'(y1_vld), 1);
        @(negedge clk);
        x1_vld = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
